// File: rtl/wiring_line_encoder_if.sv
// Byte-stream handshake bundle between a wiring-word producer, the line encoder
// and the downstream byte consumer.
interface wiring_line_encoder_if #(
    parameter int unsigned MAX_WIRING_WIDTH = 10,
    parameter int unsigned COUNT_WIDTH      = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [MAX_WIRING_WIDTH-1:0] in_wiring;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [7:0]                  out_byte;
    logic                        busy;
    logic [COUNT_WIDTH-1:0]      byte_count;

    modport master (
        output in_valid, in_wiring, in_last, out_ready,
        input  in_ready, out_valid, out_byte, busy, byte_count
    );

    modport slave (
        input  in_valid, in_wiring, in_last, out_ready,
        output in_ready, out_valid, out_byte, busy, byte_count
    );
endinterface

// File: rtl/wiring_line_encoder.sv
// Serializes one button-wiring bitmask per accepted word into ASCII text such as
// "(1,3) " or "(0,2)\n", one byte per output handshake.
module wiring_line_encoder #(
    parameter int unsigned MAX_WIRING_WIDTH = 10,
    parameter int unsigned COUNT_WIDTH      = 16
) (
    input logic            clk,
    input logic            reset,
    wiring_line_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StOpen,
        StDigit,
        StComma,
        StClose,
        StSep
    } state_e;

    state_e                      r_state;
    logic [MAX_WIRING_WIDTH-1:0] r_mask;
    logic                        r_last;
    logic                        r_in_ready;
    logic                        r_busy;
    logic                        r_out_valid;
    logic [7:0]                  r_out_byte;
    logic [COUNT_WIDTH-1:0]      r_byte_count;

    logic [3:0]                  w_low_idx;
    logic [7:0]                  w_digit;
    logic [MAX_WIRING_WIDTH-1:0] w_mask_cleared;
    logic                        w_out_hs;

    // Lowest set bit wins, so digits come out in ascending order.
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = int'(MAX_WIRING_WIDTH) - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    assign w_digit        = 8'h30 + {4'h0, w_low_idx};
    assign w_mask_cleared = r_mask & (r_mask - MAX_WIRING_WIDTH'(1));
    assign w_out_hs       = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_mask       <= '0;
            r_last       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_byte   <= 8'h00;
            r_byte_count <= '0;
        end else begin
            if (w_out_hs) begin
                r_byte_count <= r_byte_count + COUNT_WIDTH'(1);
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_mask      <= bus.in_wiring;
                        r_last      <= bus.in_last;
                        r_state     <= StOpen;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_byte  <= 8'h28;
                    end
                end
                StOpen: begin
                    if (bus.out_ready) begin
                        if (r_mask != '0) begin
                            r_state    <= StDigit;
                            r_out_byte <= w_digit;
                        end else begin
                            r_state    <= StClose;
                            r_out_byte <= 8'h29;
                        end
                    end
                end
                StDigit: begin
                    if (bus.out_ready) begin
                        r_mask <= w_mask_cleared;
                        if (w_mask_cleared != '0) begin
                            r_state    <= StComma;
                            r_out_byte <= 8'h2C;
                        end else begin
                            r_state    <= StClose;
                            r_out_byte <= 8'h29;
                        end
                    end
                end
                StComma: begin
                    // Mask was already trimmed when the previous digit left.
                    if (bus.out_ready) begin
                        r_state    <= StDigit;
                        r_out_byte <= w_digit;
                    end
                end
                StClose: begin
                    if (bus.out_ready) begin
                        r_state    <= StSep;
                        r_out_byte <= r_last ? 8'h0A : 8'h20;
                    end
                end
                StSep: begin
                    if (bus.out_ready) begin
                        r_state     <= StIdle;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_byte  <= 8'h00;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_byte   = r_out_byte;
    assign bus.byte_count = r_byte_count;

endmodule

// File: tb/tb_wiring_line_encoder.sv
// Directed bench for wiring_line_encoder: byte sequences, stalls, back-to-back words
// and mid-word reset.
module tb_wiring_line_encoder;

    logic clk = 1'b0;
    logic reset;

    wiring_line_encoder_if #(.MAX_WIRING_WIDTH(10), .COUNT_WIDTH(16)) bus ();

    wiring_line_encoder #(
        .MAX_WIRING_WIDTH(10),
        .COUNT_WIDTH(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_count = 0;

    logic [7:0] got[$];
    int cycles;
    int stall_bad;
    int busy_bad;
    bit timed_out;

    function automatic string got_hex();
        string r = "";
        foreach (got[i]) r = {r, $sformatf("%02h ", got[i])};
        return r;
    endfunction

    function automatic string exp_hex(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    // Offers one word, then drains the output, recording every handshaken byte.
    task automatic run_word(input logic [9:0] mask, input logic last, input bit rnd_ready);
        int guard;
        bit done;
        bit prev_stalled;
        logic [7:0] prev_byte;
        got.delete();
        cycles = 0;
        stall_bad = 0;
        busy_bad = 0;
        timed_out = 0;
        prev_stalled = 0;
        prev_byte = 8'h00;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_wiring = mask;
        bus.in_last   = last;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timed_out = 1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = ~last;
        bus.in_wiring = 10'h2AA;
        done = 0;
        guard = 0;
        while (!done && guard < 200) begin
            cycles++;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                if (!bus.busy) busy_bad++;
                if (prev_stalled && bus.out_byte !== prev_byte) stall_bad++;
                if (bus.out_ready) begin
                    got.push_back(bus.out_byte);
                    exp_count++;
                    prev_stalled = 0;
                    if (bus.out_byte == 8'h0A || bus.out_byte == 8'h20) done = 1;
                end else begin
                    prev_stalled = 1;
                    prev_byte = bus.out_byte;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (!done) timed_out = 1;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.out_byte !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_byte got %h want 00", bus.out_byte);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.byte_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_byte_count got %0d want 0", bus.byte_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_word(10'b00_0000_1010, 1'b0, 1'b0);
        n_cmp++;
        if (timed_out || got_hex() != exp_hex("(1,3) ")) begin
            n_fail++; $display("FAIL basic_seq got %s want %s", got_hex(), exp_hex("(1,3) "));
        end
        n_cmp++;
        if (cycles != 6) begin
            n_fail++; $display("FAIL basic_cycles got %0d want 6", cycles);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle in_ready=%b out_valid=%b want 1/0", bus.in_ready,
                     bus.out_valid);
        end
        n_cmp++;
        if (bus.byte_count !== 16'd6) begin
            n_fail++; $display("FAIL basic_count got %0d want 6", bus.byte_count);
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_fail++; $display("FAIL basic_busy got %0d low cycles want 0", busy_bad);
        end
    endtask

    task automatic test_empty();
        run_word(10'h000, 1'b1, 1'b0);
        n_cmp++;
        if (timed_out || got_hex() != exp_hex("()\n")) begin
            n_fail++; $display("FAIL empty_seq got %s want %s", got_hex(), exp_hex("()\n"));
        end
        n_cmp++;
        if (bus.byte_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL empty_count got %0d want %0d", bus.byte_count, exp_count);
        end
    endtask

    task automatic test_full();
        string e = "(0,1,2,3,4,5,6,7,8,9)\n";
        run_word(10'h3FF, 1'b1, 1'b0);
        n_cmp++;
        if (got.size() != 22) begin
            n_fail++; $display("FAIL full_len got %0d want 22", got.size());
        end
        n_cmp++;
        if (timed_out || got_hex() != exp_hex(e)) begin
            n_fail++; $display("FAIL full_seq got %s want %s", got_hex(), exp_hex(e));
        end
        n_cmp++;
        if (bus.byte_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL full_count got %0d want %0d", bus.byte_count, exp_count);
        end
    endtask

    task automatic test_stall();
        run_word(10'b00_0010_0001, 1'b0, 1'b1);
        n_cmp++;
        if (timed_out || got_hex() != exp_hex("(0,5) ")) begin
            n_fail++; $display("FAIL stall_seq got %s want %s", got_hex(), exp_hex("(0,5) "));
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_fail++; $display("FAIL stall_hold got %0d changes want 0", stall_bad);
        end
        n_cmp++;
        if (bus.byte_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL stall_count got %0d want %0d", bus.byte_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int accept2_at;
        int bubbles;
        got.delete();
        accept2_at = -1;
        bubbles = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_wiring = 10'h004;
        bus.in_last   = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready0 got %b want 1", bus.in_ready);
        end
        k = 0;
        while (got.size() < 10 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.in_wiring = 10'h003;
                bus.in_last   = 1'b1;
            end
            if (accept2_at >= 0) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                got.push_back(bus.out_byte);
                exp_count++;
            end else begin
                bubbles++;
            end
            if (bus.in_valid && bus.in_ready && accept2_at < 0) accept2_at = k;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (got_hex() != exp_hex("(2) (0,1)\n")) begin
            n_fail++;
            $display("FAIL b2b_seq got %s want %s", got_hex(), exp_hex("(2) (0,1)\n"));
        end
        n_cmp++;
        if (accept2_at != 5) begin
            n_fail++; $display("FAIL b2b_accept_cycle got %0d want 5", accept2_at);
        end
        n_cmp++;
        if (bubbles != 1) begin
            n_fail++; $display("FAIL b2b_bubbles got %0d want 1", bubbles);
        end
        n_cmp++;
        if (bus.byte_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL b2b_count got %0d want %0d", bus.byte_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_word();
        int guard;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_wiring = 10'h006;
        bus.in_last   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!(bus.out_valid && bus.out_byte == 8'h32) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++; $display("FAIL mid_reach_digit got timeout want byte 32");
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.byte_count !== 16'd0) begin
            n_fail++; $display("FAIL mid_count got %0d want 0", bus.byte_count);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
        end
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        run_word(10'h001, 1'b1, 1'b0);
        n_cmp++;
        if (timed_out || got_hex() != exp_hex("(0)\n")) begin
            n_fail++; $display("FAIL mid_after_seq got %s want %s", got_hex(), exp_hex("(0)\n"));
        end
        n_cmp++;
        if (bus.byte_count !== 16'd4) begin
            n_fail++; $display("FAIL mid_after_count got %0d want 4", bus.byte_count);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_wiring = 10'h000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
